// File: rtl/page_flip_ctrl.sv
// Debounced page-flip button: 2-FF synchroniser, debounce FSM and toggle register driving EN.
// Optional timed auto-flip when PAGE_AUTO_FLIP_EN is defined.
module page_flip_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_PERIOD     = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic EN,
  output logic flip_pulse,
  output logic btn_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || AUTO_PERIOD < 2) begin : g_bad_params
    $error("page_flip_ctrl: DEBOUNCE_CYCLES and AUTO_PERIOD must both be >= 2");
  end

  typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic          sync1, s;
  logic          accept, level_next, flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      s     <= sync1;
    end
  end

  // Saturating increment so the counter can never wrap back into range.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    level_next = btn_level;
    case (state)
      IDLE: begin
        if (s) begin
          state_next = PRESS_CHK;
          cnt_next   = CW'(1);
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          accept     = 1'b1;
          level_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_next = RELEASE_CHK;
          cnt_next   = CW'(1);
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          level_next = 1'b0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef PAGE_AUTO_FLIP_EN
  localparam int AW = $clog2(AUTO_PERIOD);
  localparam logic [AW-1:0] ACNT_LAST = AW'(AUTO_PERIOD - 1);

  logic [AW-1:0] acnt;
  logic          auto_exp;

  assign auto_exp = (state == IDLE) && (acnt == ACNT_LAST);

  // Idle-only period timer; any non-idle cycle or flip restarts the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acnt <= '0;
    end else if (state != IDLE || accept || auto_exp) begin
      acnt <= '0;
    end else begin
      acnt <= acnt + AW'(1);
    end
  end

  assign flip = accept | auto_exp;
`else
  assign flip = accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      EN         <= 1'b0;
      flip_pulse <= 1'b0;
      btn_level  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      btn_level  <= level_next;
      flip_pulse <= flip;
      if (flip) EN <= ~EN;
    end
  end

endmodule

// File: tb/tb_page_flip_ctrl.sv
// Self-checking bench for page_flip_ctrl (DEBOUNCE_CYCLES=4, AUTO_PERIOD=16) against a run-length model.
// Define PAGE_AUTO_FLIP_EN for both DUT and bench to exercise auto-flip.
module tb_page_flip_ctrl;

  localparam int DC = 4;
  localparam int AP = 16;

  logic clk;
  logic rst_n;
  logic btn_raw;
  logic EN;
  logic flip_pulse;
  logic btn_level;

  int checks   = 0;
  int failures = 0;

  // Reference model state: raw delay line, accepted level, length of the
  // current run of synced samples that disagree with it, and idle timer.
  bit m_d1, m_s, m_level, m_en, m_pulse;
  int m_run, m_aidle;

  int edge_idx, pulses, first_pulse, level_seen;
  bit auto_on;

  page_flip_ctrl #(.DEBOUNCE_CYCLES(DC), .AUTO_PERIOD(AP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .EN        (EN),
    .flip_pulse(flip_pulse),
    .btn_level (btn_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelReset();
    m_d1 = 0; m_s = 0; m_level = 0; m_en = 0; m_pulse = 0;
    m_run = 0; m_aidle = 0;
  endtask

  task automatic modelEdge(input bit raw);
    bit accept, auto_exp;
    accept   = 0;
    auto_exp = 0;
    if (auto_on) begin
      if (!m_level && m_run == 0) begin
        if (m_aidle == AP - 1) begin
          auto_exp = 1;
          m_aidle  = 0;
        end else begin
          m_aidle++;
        end
      end else begin
        m_aidle = 0;
      end
    end
    if (m_s != m_level) begin
      m_run++;
      if (m_run == DC) begin
        m_level = m_s;
        m_run   = 0;
        accept  = m_s;
      end
    end else begin
      m_run = 0;
    end
    if (accept) m_aidle = 0;
    m_pulse = accept | auto_exp;
    if (m_pulse) m_en = ~m_en;
    m_s  = m_d1;
    m_d1 = raw;
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_EN"}, int'(EN), int'(m_en));
    checkValue({tag, "_flip_pulse"}, int'(flip_pulse), int'(m_pulse));
    checkValue({tag, "_btn_level"}, int'(btn_level), int'(m_level));
  endtask

  task automatic startPhase();
    pulses      = 0;
    first_pulse = -1;
    level_seen  = 0;
  endtask

  // One clock cycle: drive btn_raw, advance model at the edge, check 1 ns later.
  task automatic applyStimulus(input bit raw, input string tag);
    btn_raw = raw;
    @(posedge clk);
    if (rst_n) begin
      modelEdge(raw);
      edge_idx++;
    end else begin
      modelReset();
    end
    #1;
    if (flip_pulse === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = edge_idx;
    end
    if (btn_level === 1'b1) level_seen = 1;
    checkOutput(tag);
  endtask

  task automatic applyRun(input bit raw, input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(raw, tag);
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_async");
    for (int i = 0; i < n; i++) applyStimulus(1'($urandom), "reset_hold");
    rst_n    = 1'b1;
    edge_idx = 0;
  endtask

  initial begin
`ifdef PAGE_AUTO_FLIP_EN
    auto_on = 1;
`else
    auto_on = 0;
`endif
    rst_n    = 1'b0;
    btn_raw  = 1'b0;
    edge_idx = 0;
    modelReset();
    startPhase();

    // Reset with a toggling button, then quiet, then a clean press rising before edge 10.
    doReset(6);
    checkValue("reset_pulses", pulses, 0);
    startPhase();
    applyRun(0, 9, "post_reset_idle");
    checkValue("post_reset_EN", int'(EN), 0);
    applyRun(1, 20, "clean_press");
    checkValue("clean_first_pulse_edge", first_pulse, 10 + 1 + DC);
    checkValue("clean_pulse_count", pulses, 1);
    checkValue("clean_EN", int'(EN), 1);
    checkValue("clean_level_held", int'(btn_level), 1);
    applyRun(0, 10, "clean_release");
    checkValue("clean_level_released", int'(btn_level), 0);

    // Bounce reject from a fresh reset.
    doReset(3);
    startPhase();
    applyRun(0, 4, "bounce_pre");
    applyRun(1, 3, "bounce_hi1");
    applyRun(0, 1, "bounce_lo");
    applyRun(1, 3, "bounce_hi2");
    applyRun(0, 10, "bounce_tail");
    checkValue("bounce_pulses", pulses, 0);
    checkValue("bounce_level_seen", level_seen, 0);
    checkValue("bounce_EN", int'(EN), 0);

    // Two full presses.
    doReset(3);
    startPhase();
    for (int p = 0; p < 2; p++) begin
      applyRun(1, 10, "two_press_hi");
      applyRun(0, 10, "two_press_lo");
    end
    checkValue("two_press_pulses", pulses, 2);
    checkValue("two_press_EN", int'(EN), 0);

    // Idle auto-flip cadence (no flips at all without the feature).
    doReset(3);
    startPhase();
    applyRun(0, 50, "auto_idle");
    checkValue("auto_idle_pulses", pulses, auto_on ? 3 : 0);
    checkValue("auto_first_edge", first_pulse, auto_on ? AP : -1);
    checkValue("auto_idle_EN", int'(EN), auto_on ? 1 : 0);
    applyRun(0, 9, "auto_align");
    applyRun(1, 10, "auto_press");
    applyRun(0, 40, "auto_after_press");

    // Reset mid-debounce: progress is discarded and counting restarts.
    doReset(3);
    applyRun(0, 3, "middeb_pre");
    applyRun(1, 4, "middeb_hi");
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("middeb_async");
    applyRun(1, 2, "middeb_hold");
    rst_n    = 1'b1;
    edge_idx = 0;
    startPhase();
    applyRun(1, 12, "middeb_after");
    checkValue("middeb_first_pulse_edge", first_pulse, 2 + DC);
    checkValue("middeb_pulses", pulses, 1);

    // Randomized bursts of bounce and clean holds.
    applyRun(0, 10, "rand_pre");
    for (int b = 0; b < 120; b++) begin
      bit lvl;
      int len;
      lvl = 1'(b & 1);
      len = (($urandom_range(0, 3) == 0) ? $urandom_range(DC + 2, 12) : $urandom_range(1, DC + 1));
      applyRun(lvl, len, "random");
    end

    // Async reset from an arbitrary state clears everything immediately.
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("final_async_reset");
    checkValue("final_EN_zero", int'(EN), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
